blink_sequencer: RTL
====================

BLINK_SEQUENCER -- requirements
Module: blink_sequencer

Interface
REQ-001 Parameter GAP_CYCLES, default 4: idle cycles, enable low, between consecutive segments.
REQ-002 Parameter TIME_SCALE, default 1: multiplier applied to table on/off times.
REQ-003 Parameter WDOG_CYCLES, default 1024: maximum RUN-state cycles per segment before fault.
REQ-004 hwclk  in  1  sole clock, rising-edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to play sequence code_sel.
REQ-007 code_sel  in  2  sequence select: 0 accept, 1 reject, 2 lockout, 3 power-on.
REQ-008 abort  in  1  cancels an in-progress sequence.
REQ-009 pat_done  in  1  done flag from the downstream pattern generator.
REQ-010 pat_enable  out  1  enable to pattern generator.
REQ-011 pat_ontime  out  32  on-time in hwclk cycles to pattern generator.
REQ-012 pat_offtime  out  32  off-time in hwclk cycles to pattern generator.
REQ-013 pat_reps  out  8  repetition count to pattern generator.
REQ-014 busy  out  1  high in any state except IDLE.
REQ-015 seg_idx  out  2  index of current segment.
REQ-016 seq_done  out  1  one-cycle pulse on normal completion.
REQ-017 err  out  1  sticky watchdog fault flag.

Function
REQ-018 Segment table (on,off,reps), fixed: code0 {(3,2,2)}; code1 {(1,1,3),(4,4,1)}; code2 {(1,1,2),(5,1,1),(1,1,2)}; code3 {(2,2,1)}.
REQ-019 pat_ontime/pat_offtime = table value * TIME_SCALE, computed 32-bit, truncated to low 32 bits; pat_reps = table reps.
REQ-020 States: IDLE, LOAD, RUN, GAP, FINISH; all outputs registered.
REQ-021 IDLE: start=1 and abort=0 latches code_sel, clears err, seg_idx<=0, next LOAD.
REQ-022 start while busy ignored; code_sel only sampled on accepted start.
REQ-023 LOAD (1 cycle): pat_* driven with segment seg_idx, pat_enable=0; next RUN.
REQ-024 RUN: pat_enable=1, pat_* held stable; pat_done=1 -> pat_enable<=0 and, if last segment, FINISH, else GAP.
REQ-025 First pat_enable=1 cycle occurs exactly 2 cycles after the start cycle (start edge +1 LOAD, +2 RUN).
REQ-026 GAP: pat_enable=0 for exactly GAP_CYCLES cycles, then seg_idx+1 and LOAD.
REQ-027 FINISH (1 cycle): seq_done=1, then IDLE.
REQ-028 pat_done ignored outside RUN.
REQ-029 abort=1 in any non-IDLE state: next cycle IDLE, pat_enable=0, no seq_done pulse, err unchanged.
REQ-030 abort and pat_done same cycle: abort wins.
REQ-031 RUN watchdog: counter reset on entry to RUN; reaching WDOG_CYCLES without pat_done -> err<=1, pat_enable<=0, IDLE, no seq_done.
REQ-032 err stays 1 until next accepted start or rst.

Reset
REQ-033 rst=1 forces immediately, independent of hwclk: state IDLE, pat_enable=0, pat_ontime=0, pat_offtime=0, pat_reps=0, busy=0, seg_idx=0, seq_done=0, err=0, all counters 0.
REQ-034 rst asserted mid-sequence aborts it with no seq_done; first start after rst release behaves as REQ-021.

Verification
REQ-035 start, code_sel=0, pattern model done after 9 cycles -> LOAD drives (3,2,2), pat_enable high 2 cycles after start, seq_done one pulse, busy low after.
REQ-036 code_sel=2, TIME_SCALE=1 -> three RUN windows with (1,1,2),(5,1,1),(1,1,2), seg_idx 0,1,2, exactly 4 enable-low cycles between RUN windows.
REQ-037 code_sel=1, assert abort during GAP -> IDLE next cycle, pat_enable 0, no seq_done; new start code 3 then plays (2,2,1).
REQ-038 pat_done held 0, WDOG_CYCLES=16 -> err=1 after 16 RUN cycles, busy 0, err clears on next start.
REQ-039 start with code 1, second start with code 0 during RUN -> ignored, code 1 completes both segments.
REQ-040 rst pulsed between clock edges during RUN -> all outputs zero without waiting for an edge; abort+pat_done same cycle -> no seq_done.

Source files
------------

// File: rtl/blink_sequencer.sv
// blink_sequencer: plays a fixed table of (on, off, reps) segments to a downstream
// pattern generator, with inter-segment gaps, abort and a per-segment RUN watchdog.
module blink_sequencer #(
  parameter int GAP_CYCLES  = 4,
  parameter int TIME_SCALE  = 1,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic        hwclk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  code_sel,
  input  logic        abort,
  input  logic        pat_done,
  output logic        pat_enable,
  output logic [31:0] pat_ontime,
  output logic [31:0] pat_offtime,
  output logic [7:0]  pat_reps,
  output logic        busy,
  output logic [1:0]  seg_idx,
  output logic        seq_done,
  output logic        err
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RUN  = 3'd2;
  localparam logic [2:0] S_GAP  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;
  localparam logic [31:0] SCALE = 32'(TIME_SCALE);
  // LOAD is itself an enable-low cycle, so GAP holds one cycle fewer than GAP_CYCLES
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 2);
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  localparam bit HAS_GAP = GAP_CYCLES > 1;

  logic [2:0]  r_state, w_nxt;
  logic [1:0]  r_code, r_seg, w_code, w_seg, w_last_idx;
  logic [31:0] r_cnt, r_on, r_off;
  logic [7:0]  r_reps;
  logic [23:0] w_ent;
  logic        r_en, r_busy, r_done, r_err, w_last, w_wdog, w_take;

  assign w_code     = (r_state == S_IDLE) ? code_sel : r_code;
  assign w_seg      = (r_state == S_IDLE) ? 2'd0 : r_seg + 2'd1;
  assign w_last_idx = (r_code == 2'd1) ? 2'd1 : (r_code == 2'd2) ? 2'd2 : 2'd0;
  assign w_last     = r_seg == w_last_idx;
  assign w_take     = r_state == S_IDLE && start && !abort;
  assign w_wdog     = r_state == S_RUN && !abort && !pat_done && r_cnt == WDOG_LAST;

  always_comb begin
    case ({w_code, w_seg})
      4'b00_00: w_ent = {8'd3, 8'd2, 8'd2};
      4'b01_00: w_ent = {8'd1, 8'd1, 8'd3};
      4'b01_01: w_ent = {8'd4, 8'd4, 8'd1};
      4'b10_00: w_ent = {8'd1, 8'd1, 8'd2};
      4'b10_01: w_ent = {8'd5, 8'd1, 8'd1};
      4'b10_10: w_ent = {8'd1, 8'd1, 8'd2};
      4'b11_00: w_ent = {8'd2, 8'd2, 8'd1};
      default:  w_ent = '0;
    endcase
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: w_nxt = w_take ? S_LOAD : S_IDLE;
      S_LOAD: w_nxt = S_RUN;
      S_RUN:  w_nxt = pat_done ? (w_last ? S_FIN : HAS_GAP ? S_GAP : S_LOAD) : w_wdog ? S_IDLE : S_RUN;
      S_GAP:  w_nxt = (r_cnt == GAP_LAST) ? S_LOAD : S_GAP;
      default: w_nxt = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) w_nxt = S_IDLE;
  end

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_code  <= '0;
      r_seg   <= '0;
      r_cnt   <= '0;
      r_on    <= '0;
      r_off   <= '0;
      r_reps  <= '0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_busy  <= w_nxt != S_IDLE;
      r_en    <= w_nxt == S_RUN;
      r_done  <= w_nxt == S_FIN;
      r_cnt   <= (w_nxt == r_state && (r_state == S_RUN || r_state == S_GAP)) ? r_cnt + 32'd1 : '0;
      if (w_take) begin
        r_code <= code_sel;
        r_err  <= 1'b0;
      end
      if (w_wdog) r_err <= 1'b1;
      if (w_nxt == S_LOAD) begin
        r_seg  <= w_seg;
        r_on   <= {24'd0, w_ent[23:16]} * SCALE;
        r_off  <= {24'd0, w_ent[15:8]} * SCALE;
        r_reps <= w_ent[7:0];
      end
    end
  end

  assign pat_enable  = r_en;
  assign pat_ontime  = r_on;
  assign pat_offtime = r_off;
  assign pat_reps    = r_reps;
  assign busy        = r_busy;
  assign seg_idx     = r_seg;
  assign seq_done    = r_done;
  assign err         = r_err;
endmodule
